// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial memory controller: access sizes,
// controller states, the IO address window default and the load extender.
// Imported by mem_ctrl; holds no logic of its own.
package mem_ctrl_pkg;

    localparam int         ADDR_W_DEF     = 32;
    localparam int         DATA_W         = 32;
    localparam logic [1:0] IO_ADDR_HI_DEF = 2'b11;

    // Access size codes carried on requiring_length
    localparam logic [1:0] REQUIRE8  = 2'b00;
    localparam logic [1:0] REQUIRE16 = 2'b01;
    localparam logic [1:0] REQUIRE32 = 2'b10;

    typedef enum logic [1:0] {
        MEMIDLE  = 2'd0,
        MEMLOAD  = 2'd1,
        MEMSTORE = 2'd2,
        MEMFETCH = 2'd3
    } mem_state_e;

    // Number of byte transfers for a size code; anything wider than a half is a word
    function automatic logic [2:0] req_bytes(input logic [1:0] len);
        case (len)
            REQUIRE8:  req_bytes = 3'd1;
            REQUIRE16: req_bytes = 3'd2;
            default:   req_bytes = 3'd4;
        endcase
    endfunction

    // Sign- or zero-extend the assembled little-endian bytes to a full word
    function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] raw,
                                                      input logic [1:0]        len,
                                                      input logic              sgn);
        case (len)
            REQUIRE8:  extend_load = {{24{sgn & raw[7]}}, raw[7:0]};
            REQUIRE16: extend_load = {{16{sgn & raw[15]}}, raw[15:0]};
            default:   extend_load = raw;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial controller between load/store buffer, instruction fetch and the 8-bit RAM/IO port.
// Latency: load/fetch done n+2 cycles after accept, store done n+1 cycles (n = 1/2/4 bytes).
// Backpressure: rdy low freezes everything and gates mem_wr; IO stores stall while io_buffer_full.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [1:0] IO_ADDR_HI = IO_ADDR_HI_DEF,
    parameter int         ADDR_W     = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              jump_wrong,
    input  logic              lsb_read_signal,
    input  logic              lsb_write_signal,
    input  logic [1:0]        requiring_length,
    input  logic [ADDR_W-1:0] to_mem_addr,
    input  logic [31:0]       to_mem_data,
    input  logic              load_signed,
    output logic              mem_load_success,
    output logic              lsb_store_done,
    output logic [31:0]       from_mem_data,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    mem_state_e        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [1:0]        len_q, len_d;
    logic              sgn_q, sgn_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;   // store data, or load bytes being assembled
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              ld_done_q, ld_done_d;
    logic              st_done_q, st_done_d;
    logic              if_done_q, if_done_d;
    logic [31:0]       from_mem_data_q, from_mem_data_d;
    logic [31:0]       if_data_q, if_data_d;

    logic [2:0] nbytes;
    logic       is_io;
    logic       lsb_done_now;
    logic [1:0] ld_lane;
    logic [1:0] st_lane;

    assign nbytes       = req_bytes(len_q);
    assign is_io        = (addr_q[17:16] == IO_ADDR_HI);
    assign lsb_done_now = ld_done_q | st_done_q;
    // Byte returned this cycle belongs to the address presented one cycle earlier
    assign ld_lane      = 2'(cnt_q - 3'd1);
    assign st_lane      = cnt_q[1:0];

    // Next-state, byte sequencing and completion pulses
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        len_d           = len_q;
        sgn_d           = sgn_q;
        addr_d          = addr_q;
        data_d          = data_q;
        mem_wr_d        = mem_wr_q;
        mem_a_d         = mem_a_q;
        mem_dout_d      = mem_dout_q;
        ld_done_d       = ld_done_q;
        st_done_d       = st_done_q;
        if_done_d       = if_done_q;
        from_mem_data_d = from_mem_data_q;
        if_data_d       = if_data_q;

        if (rdy) begin
            mem_wr_d  = 1'b0;
            ld_done_d = 1'b0;
            st_done_d = 1'b0;
            if_done_d = 1'b0;

            unique case (state_q)
                MEMIDLE: begin
                    // A requester whose done pulse is up this cycle is still dropping its level
                    if (!jump_wrong) begin
                        if (lsb_write_signal && !lsb_done_now) begin
                            state_d = MEMSTORE;
                            addr_d  = to_mem_addr;
                            len_d   = requiring_length;
                            data_d  = to_mem_data;
                            cnt_d   = 3'd0;
                            mem_a_d = to_mem_addr;
                        end else if (lsb_read_signal && !lsb_done_now) begin
                            state_d = MEMLOAD;
                            addr_d  = to_mem_addr;
                            len_d   = requiring_length;
                            sgn_d   = load_signed;
                            cnt_d   = 3'd0;
                            mem_a_d = to_mem_addr;
                        end else if (if_req && !if_done_q) begin
                            state_d = MEMFETCH;
                            addr_d  = if_addr;
                            len_d   = REQUIRE32;
                            sgn_d   = 1'b0;
                            cnt_d   = 3'd0;
                            mem_a_d = if_addr;
                        end
                    end
                end

                MEMLOAD, MEMFETCH: begin
                    if (jump_wrong) begin
                        // Speculative read is abandoned along with any bytes gathered
                        state_d = MEMIDLE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q + 3'd1 < nbytes) begin
                            mem_a_d = addr_q + ADDR_W'(cnt_q + 3'd1);
                        end
                        if (cnt_q != 3'd0 && cnt_q <= nbytes) begin
                            data_d[{ld_lane, 3'b000} +: 8] = mem_din;
                        end
                        if (cnt_q == nbytes + 3'd1) begin
                            state_d = MEMIDLE;
                            if (state_q == MEMLOAD) begin
                                ld_done_d       = 1'b1;
                                from_mem_data_d = extend_load(data_q, len_q, sgn_q);
                            end else begin
                                if_done_d = 1'b1;
                                if_data_d = data_q;
                            end
                        end
                    end
                end

                MEMSTORE: begin
                    // Stores are committed, so a flush does not interrupt them
                    if (cnt_q == nbytes) begin
                        state_d   = MEMIDLE;
                        st_done_d = 1'b1;
                    end else if (!(is_io && io_buffer_full)) begin
                        mem_wr_d   = 1'b1;
                        mem_a_d    = addr_q + ADDR_W'(cnt_q);
                        mem_dout_d = data_q[{st_lane, 3'b000} +: 8];
                        cnt_d      = cnt_q + 3'd1;
                    end
                end

                default: state_d = MEMIDLE;
            endcase
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= MEMIDLE;
            cnt_q           <= 3'd0;
            len_q           <= REQUIRE8;
            sgn_q           <= 1'b0;
            addr_q          <= '0;
            data_q          <= '0;
            mem_wr_q        <= 1'b0;
            mem_a_q         <= '0;
            mem_dout_q      <= '0;
            ld_done_q       <= 1'b0;
            st_done_q       <= 1'b0;
            if_done_q       <= 1'b0;
            from_mem_data_q <= '0;
            if_data_q       <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            len_q           <= len_d;
            sgn_q           <= sgn_d;
            addr_q          <= addr_d;
            data_q          <= data_d;
            mem_wr_q        <= mem_wr_d;
            mem_a_q         <= mem_a_d;
            mem_dout_q      <= mem_dout_d;
            ld_done_q       <= ld_done_d;
            st_done_q       <= st_done_d;
            if_done_q       <= if_done_d;
            from_mem_data_q <= from_mem_data_d;
            if_data_q       <= if_data_d;
        end
    end

    // A pending write is held, not dropped, while the global enable is low
    assign mem_wr           = mem_wr_q & rdy;
    assign mem_a            = mem_a_q;
    assign mem_dout         = mem_dout_q;
    assign mem_load_success = ld_done_q;
    assign lsb_store_done   = st_done_q;
    assign if_done          = if_done_q;
    assign from_mem_data    = from_mem_data_q;
    assign if_data          = if_data_q;

endmodule
